// File: rtl/pattern_gen_if.sv
// Video bus between the display timing generator, pattern_gen and the panel side.
// master drives the timing/mode inputs; slave (pattern_gen) drives the re-timed RGB stream.
interface pattern_gen_if #(
    parameter int COORD_W = 22
);
    logic               ivsync;
    logic               ihsync;
    logic               ide;
    logic [COORD_W-1:0] ix_coord;
    logic [COORD_W-1:0] iy_coord;
    logic [2:0]         imode;
    logic               ovsync;
    logic               ohsync;
    logic               ode;
    logic [7:0]         ored;
    logic [7:0]         ogreen;
    logic [7:0]         oblue;
    logic [2:0]         opattern;
    logic               oframe_start;

    modport master (
        output ivsync, ihsync, ide, ix_coord, iy_coord, imode,
        input  ovsync, ohsync, ode, ored, ogreen, oblue, opattern, oframe_start
    );

    modport slave (
        input  ivsync, ihsync, ide, ix_coord, iy_coord, imode,
        output ovsync, ohsync, ode, ored, ogreen, oblue, opattern, oframe_start
    );
endinterface

// File: rtl/pattern_gen.sv
// Test-pattern pixel source: 2-stage RGB pipeline with sync/DE re-timed to match.
// Define PATTERN_AUTO_EN to cycle patterns 0..5 automatically instead of following imode.
module pattern_gen #(
    parameter int H_PIXEL            = 400,
    parameter int V_PIXEL            = 240,
    parameter int COORD_W            = 22,
    parameter int BOX_SIZE           = 32,
    parameter int FRAMES_PER_PATTERN = 60
) (
    input  logic          iclk,
    input  logic          irst,
    pattern_gen_if.slave  bus
);
    localparam int                 BAR_W     = H_PIXEL / 8;
    localparam logic [8:0]         BAR_LAST  = 9'(BAR_W - 1);
    localparam logic [8:0]         BOX_X_MAX = 9'(H_PIXEL - BOX_SIZE);
    localparam logic [COORD_W-1:0] BOX_LEN   = COORD_W'(BOX_SIZE);
    localparam logic [COORD_W-1:0] Y_TOP     = COORD_W'(V_PIXEL / 2 - BOX_SIZE / 2);
    localparam logic [COORD_W-1:0] Y_BOT     = COORD_W'(V_PIXEL / 2 - BOX_SIZE / 2 + BOX_SIZE);
    localparam logic [COORD_W-1:0] X_LAST    = COORD_W'(H_PIXEL - 1);
    localparam logic [COORD_W-1:0] Y_LAST    = COORD_W'(V_PIXEL - 1);

    // Bar index stops at the last (black) bar if the line runs long.
    function automatic logic [8:0] sat_bar(input logic [8:0] bar);
        return (bar >= 9'd7) ? 9'd7 : bar + 9'd1;
    endfunction

    function automatic logic [23:0] colour(input logic [2:0] pat, input logic [8:0] bar,
                                           input logic [7:0] grey, input logic chk,
                                           input logic in_box, input logic border);
        logic [23:0] c;
        c = 24'h000000;
        case (pat)
            3'd0: begin
                case (bar)
                    9'd0:    c = 24'hFFFFFF;
                    9'd1:    c = 24'hFFFF00;
                    9'd2:    c = 24'h00FFFF;
                    9'd3:    c = 24'h00FF00;
                    9'd4:    c = 24'hFF00FF;
                    9'd5:    c = 24'hFF0000;
                    9'd6:    c = 24'h0000FF;
                    default: c = 24'h000000;
                endcase
            end
            3'd1:    c = {grey, grey, grey};
            3'd2:    c = chk ? 24'hFFFFFF : 24'h000000;
            3'd3:    c = in_box ? 24'hFF0000 : 24'h0000FF;
            3'd4:    c = 24'hFFFFFF;
            3'd5:    c = border ? 24'hFFFFFF : 24'h000000;
            default: c = 24'h000000;
        endcase
        return c;
    endfunction

    // Frame-level control state
    logic       vs_prev_q;
    logic       fs_q, fs_d;
    logic [2:0] pattern_q, pattern_d;
    logic [8:0] box_x_q, box_x_d;
`ifdef PATTERN_AUTO_EN
    localparam int FC_W = (FRAMES_PER_PATTERN > 1) ? $clog2(FRAMES_PER_PATTERN) : 1;
    logic [FC_W-1:0] fc_q, fc_d;
`endif

    // Stage 1 registers
    logic       vs_p1_q, hs_p1_q, de_p1_q;
    logic [8:0] bar_p1_q, bar_p1_d;
    logic [8:0] inbar_p1_q, inbar_p1_d;
    logic [7:0] grey_p1_q;
    logic       chk_p1_q, chk_p1_d;
    logic       box_p1_q, box_p1_d;
    logic       border_p1_q, border_p1_d;

    // Stage 2 registers
    logic        vs_p2_q, hs_p2_q, de_p2_q;
    logic [23:0] rgb_p2_q, rgb_p2_d;

    logic [COORD_W-1:0] x, y, bx;
    assign x  = bus.ix_coord;
    assign y  = bus.iy_coord;
    assign bx = COORD_W'(box_x_q);

    always_comb begin
        fs_d      = bus.ivsync & ~vs_prev_q;
        pattern_d = pattern_q;
        box_x_d   = box_x_q;
`ifdef PATTERN_AUTO_EN
        fc_d      = fc_q;
`endif
        if (fs_d) begin
            box_x_d = (box_x_q >= BOX_X_MAX) ? 9'd0 : box_x_q + 9'd1;
`ifdef PATTERN_AUTO_EN
            if (fc_q == FC_W'(FRAMES_PER_PATTERN - 1)) begin
                fc_d      = '0;
                pattern_d = (pattern_q >= 3'd5) ? 3'd0 : pattern_q + 3'd1;
            end else begin
                fc_d = fc_q + 1'b1;
            end
`else
            pattern_d = bus.imode;
`endif
        end
    end

    // Counters restart on the first active pixel, i.e. when the previous sample had DE low.
    always_comb begin
        bar_p1_d   = 9'd0;
        inbar_p1_d = 9'd0;
        if (bus.ide && de_p1_q) begin
            if (inbar_p1_q >= BAR_LAST) begin
                inbar_p1_d = 9'd0;
                bar_p1_d   = sat_bar(bar_p1_q);
            end else begin
                inbar_p1_d = inbar_p1_q + 9'd1;
                bar_p1_d   = bar_p1_q;
            end
        end
        chk_p1_d    = x[4] ^ y[4];
        box_p1_d    = (x >= bx) && (x < bx + BOX_LEN) && (y >= Y_TOP) && (y < Y_BOT);
        border_p1_d = (x == '0) || (x == X_LAST) || (y == '0) || (y == Y_LAST);
    end

    always_comb begin
        rgb_p2_d = de_p1_q ? colour(pattern_q, bar_p1_q, grey_p1_q, chk_p1_q, box_p1_q, border_p1_q)
                           : 24'h000000;
    end

    always_ff @(posedge iclk) begin
        if (irst) begin
            vs_prev_q   <= 1'b1;
            fs_q        <= 1'b0;
            pattern_q   <= 3'd0;
            box_x_q     <= 9'd0;
`ifdef PATTERN_AUTO_EN
            fc_q        <= '0;
`endif
            vs_p1_q     <= 1'b0;
            hs_p1_q     <= 1'b0;
            de_p1_q     <= 1'b0;
            bar_p1_q    <= 9'd0;
            inbar_p1_q  <= 9'd0;
            grey_p1_q   <= 8'd0;
            chk_p1_q    <= 1'b0;
            box_p1_q    <= 1'b0;
            border_p1_q <= 1'b0;
            vs_p2_q     <= 1'b0;
            hs_p2_q     <= 1'b0;
            de_p2_q     <= 1'b0;
            rgb_p2_q    <= 24'h000000;
        end else begin
            vs_prev_q   <= bus.ivsync;
            fs_q        <= fs_d;
            pattern_q   <= pattern_d;
            box_x_q     <= box_x_d;
`ifdef PATTERN_AUTO_EN
            fc_q        <= fc_d;
`endif
            // stage 1: register inputs and per-pixel pattern terms
            vs_p1_q     <= bus.ivsync;
            hs_p1_q     <= bus.ihsync;
            de_p1_q     <= bus.ide;
            bar_p1_q    <= bar_p1_d;
            inbar_p1_q  <= inbar_p1_d;
            grey_p1_q   <= x[7:0];
            chk_p1_q    <= chk_p1_d;
            box_p1_q    <= box_p1_d;
            border_p1_q <= border_p1_d;
            // stage 2: final colour, blanked outside DE
            vs_p2_q     <= vs_p1_q;
            hs_p2_q     <= hs_p1_q;
            de_p2_q     <= de_p1_q;
            rgb_p2_q    <= rgb_p2_d;
        end
    end

    assign bus.ovsync       = vs_p2_q;
    assign bus.ohsync       = hs_p2_q;
    assign bus.ode          = de_p2_q;
    assign bus.ored         = rgb_p2_q[23:16];
    assign bus.ogreen       = rgb_p2_q[15:8];
    assign bus.oblue        = rgb_p2_q[7:0];
    assign bus.opattern     = pattern_q;
    assign bus.oframe_start = fs_q;
endmodule
